sequential_shift_add_multiplier: RTL and testbench



---
 rtl/sequential_shift_add_multiplier.sv | 124 ++++++++++++
 tb/tb_sequential_shift_add_multiplier.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sequential_shift_add_multiplier.sv
// Purpose: unsigned 8x8->16 multiplier that reuses one 8-bit ripple adder over eight add-and-shift steps.
// Latency: done pulses 9 cycles after start is sampled in IDLE; minimum start-to-start spacing is 10 cycles.
// Backpressure: start is only sampled in IDLE; while busy it is ignored (not queued) and a/b are not looked at.
module sequential_shift_add_multiplier (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] product,
    output logic        done,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [7:0]  r_m;        // multiplicand
    logic [7:0]  r_a;        // accumulator (high half of the running product)
    logic [7:0]  r_q;        // multiplier, shifted out as the low product bits shift in
    logic [2:0]  r_cnt;      // iteration counter, 0..7
    logic [15:0] r_product;

    logic [7:0]  w_op1;
    logic [7:0]  w_op2;
    logic [7:0]  w_sum;
    logic        w_cout;
    logic        w_last_step;

    assign w_op1       = r_a;
    assign w_op2       = r_q[0] ? r_m : 8'h00;
    assign w_last_step = (r_cnt == 3'd7);

    // Single 8-bit carry-ripple adder shared by every iteration; carry-in is tied low.
    always_comb begin : ripple
        logic c;
        c     = 1'b0;
        w_sum = 8'h00;
        for (int i = 0; i < 8; i++) begin
            w_sum[i] = w_op1[i] ^ w_op2[i] ^ c;
            c        = (w_op1[i] & w_op2[i]) | (c & (w_op1[i] ^ w_op2[i]));
        end
        w_cout = c;
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode: accept in IDLE, eight RUN steps, one DONE cycle, back to IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: w_next_state = start ? ST_RUN : ST_IDLE;
            ST_RUN:  w_next_state = w_last_step ? ST_DONE : ST_RUN;
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Status outputs decoded purely from the registered state, so no path from start.
    always_comb begin
        done = 1'b0;
        busy = 1'b0;
        case (r_state)
            ST_RUN:  busy = 1'b1;
            ST_DONE: begin
                done = 1'b1;
                busy = 1'b1;
            end
            default: begin
                done = 1'b0;
                busy = 1'b0;
            end
        endcase
    end

    // Datapath: latch operands on accept, then add-and-shift once per RUN cycle.
    // The adder carry lands in A[7] so the 9-bit partial sum is never truncated.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m       <= 8'h00;
            r_a       <= 8'h00;
            r_q       <= 8'h00;
            r_cnt     <= 3'd0;
            r_product <= 16'h0000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_m   <= a;
                        r_q   <= b;
                        r_a   <= 8'h00;
                        r_cnt <= 3'd0;
                    end
                end
                ST_RUN: begin
                    r_a   <= {w_cout, w_sum[7:1]};
                    r_q   <= {w_sum[0], r_q[7:1]};
                    r_cnt <= r_cnt + 3'd1;
                    if (w_last_step) begin
                        r_product <= {w_cout, w_sum[7:1], w_sum[0], r_q[7:1]};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign product = r_product;

endmodule

// File: tb/tb_sequential_shift_add_multiplier.sv
// Purpose: randomized and directed self-checking bench for the shift-add multiplier.
// Latency: expects done 9 cycles after the cycle in which start is driven.
// Backpressure: drives start only when the DUT is idle, except in the hold-start scenario.
module tb_sequential_shift_add_multiplier;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] product;
    logic        done;
    logic        busy;

    int n_checks;
    int n_pass;
    int done_seen;

    sequential_shift_add_multiplier dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .product (product),
        .done    (done),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent count of done pulses, sampled away from the active edge.
    always @(negedge clk) begin
        if (done === 1'b1) done_seen++;
    end

    // Reference model: plain unsigned multiplication.
    function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
        return 16'(x) * 16'(y);
    endfunction

    // Issues one operation from idle and waits (bounded) for done.
    // lat counts cycles from the cycle start is driven to the cycle done is seen; -1 on timeout.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input bit scramble,
                          output logic [15:0] prod, output int lat, output int busy_cnt);
        bit found;
        found    = 1'b0;
        prod     = 16'hxxxx;
        busy_cnt = 0;
        @(negedge clk);
        a     = ta;
        b     = tb_;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        for (int k = 0; k < 40; k++) begin
            if (scramble) begin
                a = 8'($urandom);
                b = 8'($urandom);
            end
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                prod  = product;
                found = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
        if (!found) lat = -1;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        repeat (3) @(negedge clk);
        n_checks++;
        if (product !== 16'h0000) $display("FAIL reset_product: got %h expected 0000", product);
        else n_pass++;
        n_checks++;
        if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [15:0] p;
        int lat, bc;
        run_op(8'd13, 8'd11, 1'b0, p, lat, bc);
        n_checks++;
        if (p !== 16'h008F) $display("FAIL basic_product: got %h expected 008f", p);
        else n_pass++;
        n_checks++;
        if (p !== ref_mul(8'd13, 8'd11)) $display("FAIL basic_model: got %h expected %h", p, ref_mul(8'd13, 8'd11));
        else n_pass++;
        n_checks++;
        if (lat != 9) $display("FAIL basic_latency: got %0d expected 9", lat);
        else n_pass++;
        n_checks++;
        if (bc != 9) $display("FAIL basic_busy_cycles: got %0d expected 9", bc);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) $display("FAIL basic_done_pulse_width: got %b expected 0", done);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL basic_busy_after: got %b expected 0", busy);
        else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++;
        if (product !== 16'h008F) $display("FAIL basic_product_hold: got %h expected 008f", product);
        else n_pass++;
    endtask

    task automatic test_corners();
        logic [7:0]  ca [4];
        logic [7:0]  cb [4];
        logic [15:0] ce [4];
        logic [15:0] p;
        int lat, bc;
        ca[0] = 8'hFF; cb[0] = 8'hFF; ce[0] = 16'hFE01;
        ca[1] = 8'h00; cb[1] = 8'hFF; ce[1] = 16'h0000;
        ca[2] = 8'hA5; cb[2] = 8'h00; ce[2] = 16'h0000;
        ca[3] = 8'h80; cb[3] = 8'h02; ce[3] = 16'h0100;
        for (int i = 0; i < 4; i++) begin
            run_op(ca[i], cb[i], 1'b0, p, lat, bc);
            n_checks++;
            if (p !== ce[i]) $display("FAIL corner_%0d_product: %h*%h got %h expected %h", i, ca[i], cb[i], p, ce[i]);
            else n_pass++;
            n_checks++;
            if (lat != 9) $display("FAIL corner_%0d_latency: got %0d expected 9", i, lat);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int d1, d2, ndone;
        logic [15:0] p1, p2;
        logic busy9;
        d1 = -1; d2 = -1; ndone = 0;
        p1 = 16'hxxxx; p2 = 16'hxxxx; busy9 = 1'bx;
        @(negedge clk);
        a     = 8'h0F;
        b     = 8'h0F;
        start = 1'b1;
        for (int c = 0; c <= 19; c++) begin
            @(negedge clk);
            if (c == 3) begin
                a = 8'h10;
                b = 8'h10;
            end
            if (done === 1'b1) begin
                ndone++;
                if (d1 < 0) begin
                    d1 = c;
                    p1 = product;
                end else if (d2 < 0) begin
                    d2 = c;
                    p2 = product;
                end
            end
            if (c == 9) busy9 = busy;
            if (c == 19) start = 1'b0;
        end
        n_checks++;
        if (p1 !== ref_mul(8'h0F, 8'h0F)) $display("FAIL b2b_first_product: got %h expected %h", p1, ref_mul(8'h0F, 8'h0F));
        else n_pass++;
        n_checks++;
        if (d1 != 8) $display("FAIL b2b_first_done_cycle: got %0d expected 8", d1);
        else n_pass++;
        n_checks++;
        if (busy9 !== 1'b0) $display("FAIL b2b_idle_gap_busy: got %b expected 0", busy9);
        else n_pass++;
        n_checks++;
        if (p2 !== 16'h0100) $display("FAIL b2b_second_product: got %h expected 0100", p2);
        else n_pass++;
        n_checks++;
        if (d2 != 18) $display("FAIL b2b_second_done_cycle: got %0d expected 18", d2);
        else n_pass++;
        n_checks++;
        if (ndone != 2) $display("FAIL b2b_done_count: got %0d expected 2", ndone);
        else n_pass++;
        repeat (12) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL b2b_no_third_accept: busy got %b expected 0", busy);
        else n_pass++;
    endtask

    task automatic test_reset_midrun();
        int d0;
        logic [15:0] p;
        int lat, bc;
        @(negedge clk);
        a     = 8'h12;
        b     = 8'h34;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", busy);
        else n_pass++;
        n_checks++;
        if (product !== 16'h0000) $display("FAIL midrst_product: got %h expected 0000", product);
        else n_pass++;
        d0 = done_seen;
        repeat (15) @(negedge clk);
        n_checks++;
        if (done_seen != d0) $display("FAIL midrst_no_done: got %0d pulses expected 0", done_seen - d0);
        else n_pass++;
        run_op(8'h12, 8'h34, 1'b0, p, lat, bc);
        n_checks++;
        if (p !== 16'h03A8) $display("FAIL midrst_rerun_product: got %h expected 03a8", p);
        else n_pass++;
        n_checks++;
        if (lat != 9) $display("FAIL midrst_rerun_latency: got %0d expected 9", lat);
        else n_pass++;
    endtask

    task automatic test_random();
        int d0, bad_lat;
        logic [7:0]  ta, tb_;
        logic [15:0] p, exp;
        int lat, bc;
        bad_lat = 0;
        @(negedge clk);
        d0 = done_seen;
        for (int i = 0; i < 1000; i++) begin
            ta  = 8'($urandom);
            tb_ = 8'($urandom);
            exp = ref_mul(ta, tb_);
            run_op(ta, tb_, 1'b1, p, lat, bc);
            if (lat != 9) bad_lat++;
            n_checks++;
            if (p !== exp) $display("FAIL rand_%0d_product: %h*%h got %h expected %h", i, ta, tb_, p, exp);
            else n_pass++;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (bad_lat != 0) $display("FAIL rand_latency: got %0d ops off 9 cycles expected 0", bad_lat);
        else n_pass++;
        n_checks++;
        if (done_seen - d0 != 1000) $display("FAIL rand_done_count: got %0d expected 1000", done_seen - d0);
        else n_pass++;
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        done_seen = 0;
        rst       = 1'b1;
        start     = 1'b0;
        a         = 8'h00;
        b         = 8'h00;
        test_reset();
        test_basic();
        test_corners();
        test_back_to_back();
        test_reset_midrun();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
